// File: rtl/pwm_duty_sched.sv
// Ramped PWM duty scheduler: a tick starts one sweep that moves each channel's duty one step toward its target.
// Optional sweep-complete interrupt is enabled by defining PWM_DUTY_SCHED_IRQ_EN.
module pwm_duty_sched #(
  parameter int CNT_LENGTH = 16,
  parameter int TIM_NUM    = 8
) (
  input  logic                                              sys_clk,
  input  logic                                              sys_rst,
  input  logic                                              tick,
  input  logic                                              wr_en,
  input  logic [((TIM_NUM > 1) ? $clog2(TIM_NUM) : 1)-1:0]  wr_ch,
  input  logic [CNT_LENGTH-1:0]                             wr_target,
  input  logic [CNT_LENGTH-1:0]                             wr_step,
  output logic [TIM_NUM*CNT_LENGTH-1:0]                     duty_out,
  output logic [TIM_NUM-1:0]                                done_mask,
  output logic                                              busy,
  output logic                                              overrun,
  input  logic                                              ovr_clr,
  output logic                                              irq,
  input  logic                                              irq_clr,
  output logic                                              dbg_state
);

  localparam int IW = (TIM_NUM > 1) ? $clog2(TIM_NUM) : 1;
  localparam logic [IW-1:0] LAST = IW'(TIM_NUM - 1);

  // Handshake: tick is a single-cycle request accepted only while busy=0;
  // a tick seen while busy=1 is dropped and flagged on the sticky overrun bit.
  typedef enum logic {IDLE, SCAN} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CNT_LENGTH-1:0] cur_q  [TIM_NUM];
  logic [CNT_LENGTH-1:0] cur_d  [TIM_NUM];
  logic [CNT_LENGTH-1:0] tgt_q  [TIM_NUM];
  logic [CNT_LENGTH-1:0] tgt_d  [TIM_NUM];
  logic [CNT_LENGTH-1:0] step_q [TIM_NUM];
  logic [CNT_LENGTH-1:0] step_d [TIM_NUM];
  logic [TIM_NUM-1:0]    done_q, done_d;
  logic                  overrun_q, overrun_d;
  logic                  svc_en;
  logic [CNT_LENGTH-1:0] svc_val;

  // Differences are taken in the direction that cannot underflow, and the
  // step is only added/subtracted when it cannot pass the target, so no wrap.
  function automatic logic [CNT_LENGTH-1:0] ramp(input logic [CNT_LENGTH-1:0] c,
                                                 input logic [CNT_LENGTH-1:0] t,
                                                 input logic [CNT_LENGTH-1:0] s);
    logic [CNT_LENGTH-1:0] r;
    r = c;
    if (c < t)      r = ((s == '0) || ((t - c) <= s)) ? t : c + s;
    else if (c > t) r = ((s == '0) || ((c - t) <= s)) ? t : c - s;
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cur_d     = cur_q;
    tgt_d     = tgt_q;
    step_d    = step_q;
    done_d    = done_q;
    overrun_d = (overrun_q & ~ovr_clr) | (tick & (state_q == SCAN));
    svc_val   = ramp(cur_q[idx_q], tgt_q[idx_q], step_q[idx_q]);
    svc_en    = (state_q == SCAN) && !(wr_en && (wr_ch == idx_q));

    if (svc_en) cur_d[idx_q] = svc_val;
    if (wr_en) begin
      tgt_d[wr_ch]  = wr_target;
      step_d[wr_ch] = wr_step;
    end

    // done_mask is registered from next state so it matches the registers it describes
    for (int k = 0; k < TIM_NUM; k++) done_d[k] = (cur_d[k] == tgt_d[k]);

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        if (idx_q == LAST) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      done_q    <= '1;
      overrun_q <= 1'b0;
      for (int k = 0; k < TIM_NUM; k++) begin
        cur_q[k]  <= '0;
        tgt_q[k]  <= '0;
        step_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      cur_q     <= cur_d;
      tgt_q     <= tgt_d;
      step_q    <= step_d;
    end
  end

  for (genvar k = 0; k < TIM_NUM; k++) begin : g_duty
    assign duty_out[k*CNT_LENGTH +: CNT_LENGTH] = cur_q[k];
  end

  assign done_mask = done_q;
  assign busy      = (state_q == SCAN);
  assign overrun   = overrun_q;
  assign dbg_state = (state_q == SCAN);

`ifdef PWM_DUTY_SCHED_IRQ_EN
  logic changed_q, changed_d;
  logic irq_q, irq_d;

  always_comb begin
    changed_d = changed_q;
    irq_d     = irq_q & ~irq_clr;
    if ((state_q == IDLE) && tick) changed_d = 1'b0;
    if (svc_en && (svc_val != cur_q[idx_q])) changed_d = 1'b1;
    if ((state_q == SCAN) && (idx_q == LAST) && changed_d && (&done_d)) irq_d = 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      changed_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      changed_q <= changed_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr;
  assign irq = 1'b0;
`endif

endmodule
